// File: rtl/arbitro_balance_if.sv
// Handshake and balance bus between the two terminals and the balance arbiter.
// The slave modport is the arbiter side; master is the terminal/host side.
interface arbitro_balance_if #(
  parameter int ANCHO_MONTO   = 32,
  parameter int ANCHO_BALANCE = 64
);
  logic                     cargar_balance;
  logic [ANCHO_BALANCE-1:0] balance_inicial;
  logic                     req0;
  logic                     req1;
  logic                     tipo0;
  logic                     tipo1;
  logic [ANCHO_MONTO-1:0]   monto0;
  logic [ANCHO_MONTO-1:0]   monto1;
  logic                     gnt0;
  logic                     gnt1;
  logic                     ack;
  logic [ANCHO_BALANCE-1:0] balance_actualizado;
  logic                     balance_stb;
  logic                     entregar_dinero;
  logic                     fondos_insuficientes;
  logic                     ocupado;

  modport slave (
    input  cargar_balance, balance_inicial,
    input  req0, req1, tipo0, tipo1, monto0, monto1,
    output gnt0, gnt1, ack, balance_actualizado, balance_stb,
    output entregar_dinero, fondos_insuficientes, ocupado
  );

  modport master (
    output cargar_balance, balance_inicial,
    output req0, req1, tipo0, tipo1, monto0, monto1,
    input  gnt0, gnt1, ack, balance_actualizado, balance_stb,
    input  entregar_dinero, fondos_insuficientes, ocupado
  );
endinterface

// File: rtl/arbitro_balance.sv
// Round-robin arbiter for two terminals sharing one account balance.
// Each granted transaction runs GRANT -> CALC -> RESP and strobes its result in RESP.
module arbitro_balance #(
  parameter int ANCHO_MONTO   = 32,
  parameter int ANCHO_BALANCE = 64
) (
  input logic              clk,
  input logic              reset,
  arbitro_balance_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] CALC  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]               estado;
  logic                     gnt0_q;
  logic                     gnt1_q;
  logic                     prio;
  logic [ANCHO_BALANCE-1:0] balance;
  logic                     entregar_q;
  logic                     fondos_q;
  logic                     tipo_q;
  logic [ANCHO_MONTO-1:0]   monto_q;

  logic                     gana1;
  logic                     hay_req;
  logic                     arbitra;
  logic [ANCHO_BALANCE-1:0] balance_nuevo;
  logic                     entregar_nuevo;
  logic                     fondos_nuevo;

  function automatic logic [ANCHO_BALANCE-1:0] extender(input logic [ANCHO_MONTO-1:0] m);
    return ANCHO_BALANCE'(m);
  endfunction

  function automatic logic [ANCHO_BALANCE-1:0] suma_sat(input logic [ANCHO_BALANCE-1:0] a,
                                                        input logic [ANCHO_BALANCE-1:0] b);
    logic [ANCHO_BALANCE:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ANCHO_BALANCE] ? {ANCHO_BALANCE{1'b1}} : s[ANCHO_BALANCE-1:0];
  endfunction

  // prio names the terminal that wins a tie; it always points away from the last one served.
  assign hay_req = bus.req0 | bus.req1;
  assign gana1   = bus.req1 & (~bus.req0 | prio);
  assign arbitra = (estado == IDLE) & ~bus.cargar_balance & hay_req;

  always_comb begin
    balance_nuevo  = balance;
    entregar_nuevo = 1'b0;
    fondos_nuevo   = 1'b0;
    if (!tipo_q) begin
      balance_nuevo = suma_sat(balance, extender(monto_q));
    end else if (extender(monto_q) > balance) begin
      fondos_nuevo = 1'b1;
    end else begin
      balance_nuevo  = balance - extender(monto_q);
      entregar_nuevo = (monto_q != '0);
    end
  end

  // ---- control and balance state ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado     <= IDLE;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      prio       <= 1'b0;
      balance    <= '0;
      entregar_q <= 1'b0;
      fondos_q   <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (bus.cargar_balance) begin
            balance <= bus.balance_inicial;
          end else if (hay_req) begin
            estado <= GRANT;
            gnt0_q <= ~gana1;
            gnt1_q <= gana1;
            prio   <= ~gana1;
          end
        end
        GRANT: estado <= CALC;
        CALC: begin
          estado     <= RESP;
          balance    <= balance_nuevo;
          entregar_q <= entregar_nuevo;
          fondos_q   <= fondos_nuevo;
        end
        RESP: begin
          estado     <= IDLE;
          gnt0_q     <= 1'b0;
          gnt1_q     <= 1'b0;
          entregar_q <= 1'b0;
          fondos_q   <= 1'b0;
        end
        default: estado <= IDLE;
      endcase
    end
  end

  // ---- transaction operands, captured once at grant ----
  always_ff @(posedge clk) begin
    if (arbitra) begin
      tipo_q  <= gana1 ? bus.tipo1 : bus.tipo0;
      monto_q <= gana1 ? bus.monto1 : bus.monto0;
    end
  end

  assign bus.gnt0                 = gnt0_q;
  assign bus.gnt1                 = gnt1_q;
  assign bus.ack                  = (estado == RESP);
  assign bus.balance_stb          = (estado == RESP);
  assign bus.entregar_dinero      = (estado == RESP) & entregar_q;
  assign bus.fondos_insuficientes = (estado == RESP) & fondos_q;
  assign bus.ocupado              = (estado != IDLE);
  assign bus.balance_actualizado  = balance;

endmodule

// File: tb/tb_arbitro_balance.sv
// Randomized bench for arbitro_balance against a transaction-level account model.
module tb_arbitro_balance;
  localparam int AM = 32;
  localparam int AB = 64;
  localparam logic [AB-1:0] MAXB = {AB{1'b1}};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arbitro_balance_if #(.ANCHO_MONTO(AM), .ANCHO_BALANCE(AB)) bus();
  arbitro_balance #(.ANCHO_MONTO(AM), .ANCHO_BALANCE(AB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk;
  int n_pass;

  logic [AB-1:0] m_bal;
  bit            m_prio;
  bit            pend  [2];
  bit            ptipo [2];
  logic [AM-1:0] pmonto[2];

  task automatic chk(input string tag, input logic [AB-1:0] obs, input logic [AB-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // {gnt0, gnt1, ack, balance_stb, entregar_dinero, fondos_insuficientes, ocupado}
  function automatic logic [6:0] ctl();
    return {bus.gnt0, bus.gnt1, bus.ack, bus.balance_stb,
            bus.entregar_dinero, bus.fondos_insuficientes, bus.ocupado};
  endfunction

  task automatic apply_reqs();
    bus.req0   = pend[0];
    bus.tipo0  = ptipo[0];
    bus.monto0 = pmonto[0];
    bus.req1   = pend[1];
    bus.tipo1  = ptipo[1];
    bus.monto1 = pmonto[1];
  endtask

  function automatic logic [AB-1:0] rand_bal();
    case ($urandom_range(0, 3))
      0:       return AB'($urandom_range(0, 5000));
      1:       return MAXB - AB'($urandom_range(0, 3000));
      2:       return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [AM-1:0] rand_monto(input logic [AB-1:0] bal);
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return AM'($urandom_range(0, 2000));
      2:       return $urandom;
      3:       return (bal <= AB'(32'hFFFF_FFFF)) ? bal[AM-1:0] : $urandom;
      default: return (bal <  AB'(32'hFFFF_FFFF)) ? bal[AM-1:0] + 1'b1 : $urandom;
    endcase
  endfunction

  // Called on a falling edge with the arbiter idle; leaves it idle on a falling edge.
  task automatic run_txn(input bit do_load, input logic [AB-1:0] lv, input bit load_busy);
    bit            w;
    bit            ent;
    bit            fon;
    logic [AB-1:0] old_bal;
    logic [AB-1:0] exp_bal;
    logic [AB-1:0] amt;
    logic [6:0]    g;
    apply_reqs();
    if (do_load) begin
      bus.cargar_balance  = 1'b1;
      bus.balance_inicial = lv;
      @(negedge clk);
      m_bal = lv;
      chk("load_bal", bus.balance_actualizado, m_bal);
      chk("load_idle", ctl(), 7'b0);
      bus.cargar_balance = 1'b0;
    end
    w   = (pend[0] && pend[1]) ? m_prio : pend[1];
    amt = AB'(pmonto[w]);
    old_bal = m_bal;
    ent = 1'b0;
    fon = 1'b0;
    if (!ptipo[w]) begin
      exp_bal = (MAXB - m_bal < amt) ? MAXB : m_bal + amt;
    end else if (amt > m_bal) begin
      exp_bal = m_bal;
      fon = 1'b1;
    end else begin
      exp_bal = m_bal - amt;
      ent = (amt != 0);
    end
    g = w ? 7'b0100000 : 7'b1000000;

    @(negedge clk);
    chk("grant", ctl(), g | 7'b0000001);
    chk("grant_bal", bus.balance_actualizado, old_bal);
    if (w) begin
      bus.tipo1 = 1'($urandom); bus.monto1 = $urandom;
    end else begin
      bus.tipo0 = 1'($urandom); bus.monto0 = $urandom;
    end
    if (load_busy) begin
      bus.cargar_balance  = 1'b1;
      bus.balance_inicial = rand_bal();
    end

    @(negedge clk);
    chk("calc", ctl(), g | 7'b0000001);
    chk("calc_bal", bus.balance_actualizado, old_bal);

    @(negedge clk);
    m_bal = exp_bal;
    chk("resp", ctl(), g | {2'b0, 1'b1, 1'b1, ent, fon, 1'b1});
    chk("resp_bal", bus.balance_actualizado, m_bal);
    bus.cargar_balance = 1'b0;
    pend[w] = 1'b0;
    apply_reqs();
    m_prio = ~w;

    @(negedge clk);
    chk("idle", ctl(), 7'b0);
    chk("idle_bal", bus.balance_actualizado, m_bal);
  endtask

  task automatic set_req(input int t, input bit tp, input logic [AM-1:0] m);
    pend[t]   = 1'b1;
    ptipo[t]  = tp;
    pmonto[t] = m;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    m_bal = '0;
    m_prio = 1'b0;
    pend = '{0, 0};
    ptipo = '{0, 0};
    pmonto = '{0, 0};
    bus.cargar_balance  = 1'b0;
    bus.balance_inicial = '0;
    apply_reqs();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_ctl", ctl(), 7'b0);
    chk("rst_bal", bus.balance_actualizado, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Both terminals held: alternate service starting with terminal 0.
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b0, 32'd10);
      set_req(1, 1'b0, 32'd20);
      run_txn(1'b0, '0, 1'b0);
    end
    pend = '{0, 0};
    apply_reqs();

    set_req(0, 1'b1, 32'd300);
    run_txn(1'b1, 64'd1000, 1'b0);
    set_req(1, 1'b1, 32'd701);
    run_txn(1'b0, '0, 1'b0);
    set_req(0, 1'b0, 32'd100);
    run_txn(1'b1, MAXB - 64'd9, 1'b0);
    set_req(1, 1'b1, 32'd500);
    run_txn(1'b1, 64'd500, 1'b0);
    set_req(0, 1'b1, 32'd1);
    run_txn(1'b0, '0, 1'b1);

    // Terminal 1 holds priority, then a reset lands in CALC.
    set_req(0, 1'b0, 32'd5);
    set_req(1, 1'b0, 32'd7);
    apply_reqs();
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_calc", ctl(), 7'b0100001);
    reset = 1'b0;
    #1;
    chk("async_rst_ctl", ctl(), 7'b0);
    chk("async_rst_bal", bus.balance_actualizado, '0);
    @(posedge clk);
    #1;
    chk("hold_rst_ctl", ctl(), 7'b0);
    @(negedge clk);
    reset = 1'b1;
    m_bal = '0;
    m_prio = 1'b0;
    run_txn(1'b0, '0, 1'b0);
    pend = '{0, 0};
    apply_reqs();

    for (int k = 0; k < 300; k++) begin
      for (int t = 0; t < 2; t++) begin
        if (!pend[t] && $urandom_range(0, 1) == 1)
          set_req(t, 1'($urandom), rand_monto(m_bal));
      end
      if (!pend[0] && !pend[1])
        set_req($urandom_range(0, 1), 1'($urandom), rand_monto(m_bal));
      run_txn($urandom_range(0, 5) == 0, rand_bal(), $urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
